pio_count_timer: RTL and testbench

Downstream consumer of the Nios-driven 16-bit COUNT PIO output. Captures the PIO count value on a start request and counts it down to zero at a prescaled tick rate. On reaching zero it raises a one-cycle done pulse and a sticky expired flag, which drive LEDs or feed an input PIO for software polling. Runs entirely in the PIO clock domain.

---
 rtl/pio_count_timer_pkg.sv | 19 +
 rtl/pio_count_timer_tick_gen.sv | 33 +++
 rtl/pio_count_timer.sv | 123 ++++++++++++
 tb/tb_pio_count_timer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_count_timer_pkg.sv
// Shared types and constants for the PIO-driven countdown timer.
// Optional auto-reload mode is enabled by defining PIO_COUNT_TIMER_AUTO_RELOAD_EN.
package pio_count_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_PRESCALE = 50000;

    // Prescaler width is $clog2(prescale), never narrower than one bit.
    function automatic int prescale_width(input int prescale);
        return (prescale <= 1) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/pio_count_timer_tick_gen.sv
// Prescaler for pio_count_timer: emits a one-cycle tick every PRESCALE
// enabled cycles; clear restarts the period from zero.
module tick_gen
    import pio_count_timer_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            PW   = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] count;

    assign tick = enable && !clear && (count == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) count <= '0;
            else               count <= count + PW'(1);
        end
    end

endmodule

// File: rtl/pio_count_timer.sv
// Countdown timer fed by the Nios COUNT PIO: loads on a start rise, counts to
// zero at the prescaled rate, pulses done and sets expired. Optional feature
// macro: PIO_COUNT_TIMER_AUTO_RELOAD_EN (restart from the reload value after DONE).
module pio_count_timer
    import pio_count_timer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] count_in,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] count_now,
    output logic             busy,
    output logic             done,
    output logic             expired,
    output state_t           state_dbg
);

    state_t           state, state_next;
    logic [WIDTH-1:0] counter, counter_next;
    logic             expired_next;
    logic             start_d, start_armed;
    logic             rise, load, presc_clear, tick;
`ifdef PIO_COUNT_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload, reload_next;
`endif

    // start_armed stays low after reset until start is seen low, so a level
    // still held high across a reset cannot masquerade as a fresh request.
    assign rise = start && !start_d && start_armed;
    assign load = rise && !abort && (state != DONE);

    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (presc_clear),
        .enable  (state == RUN),
        .tick    (tick)
    );

    always_comb begin
        state_next   = state;
        counter_next = counter;
        expired_next = expired;
        presc_clear  = 1'b0;
`ifdef PIO_COUNT_TIMER_AUTO_RELOAD_EN
        reload_next  = reload;
`endif
        if (load) begin
            counter_next = count_in;
            presc_clear  = 1'b1;
`ifdef PIO_COUNT_TIMER_AUTO_RELOAD_EN
            reload_next  = count_in;
`endif
            if (count_in == '0) begin
                expired_next = 1'b1;
                state_next   = DONE;
            end else begin
                expired_next = 1'b0;
                state_next   = RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    if (abort) begin
                        state_next = IDLE;
                    end else if (tick && counter != '0) begin
                        counter_next = counter - WIDTH'(1);
                        if (counter == WIDTH'(1)) begin
                            expired_next = 1'b1;
                            state_next   = DONE;
                        end
                    end
                end
                DONE: begin
`ifdef PIO_COUNT_TIMER_AUTO_RELOAD_EN
                    if (!abort && reload != '0) begin
                        counter_next = reload;
                        presc_clear  = 1'b1;
                        state_next   = RUN;
                    end else begin
                        state_next = IDLE;
                    end
`else
                    state_next = IDLE;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            counter     <= '0;
            expired     <= 1'b0;
            start_d     <= 1'b0;
            start_armed <= 1'b0;
`ifdef PIO_COUNT_TIMER_AUTO_RELOAD_EN
            reload      <= '0;
`endif
        end else begin
            state       <= state_next;
            counter     <= counter_next;
            expired     <= expired_next;
            start_d     <= start;
            if (!start) start_armed <= 1'b1;
`ifdef PIO_COUNT_TIMER_AUTO_RELOAD_EN
            reload      <= reload_next;
`endif
        end
    end

    assign count_now = counter;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_pio_count_timer.sv
// Self-checking bench for pio_count_timer at PRESCALE = 4 with randomized
// load values, abort points and restart points against a timeline model.
module tb_pio_count_timer;
    import pio_count_timer_pkg::*;

    localparam int W = 16;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] count_in = '0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] count_now;
    logic         busy, done, expired;
    state_t       state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int n, a, m;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    pio_count_timer #(.WIDTH(W), .PRESCALE(P)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .count_in  (count_in),
        .start     (start),
        .abort     (abort),
        .count_now (count_now),
        .busy      (busy),
        .done      (done),
        .expired   (expired),
        .state_dbg (state_dbg)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one clock edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected count t edges after a load of n, from the decrement-every-P rule.
    function automatic logic [W-1:0] model_count(input int load_val, input int t);
        int v;
        v = load_val - t / P;
        if (v < 0) v = 0;
        return W'(v);
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; count_in = '0;
        step(); step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        n_checks++;
        if (count_now !== '0) $display("FAIL reset_count got=%0d exp=0", count_now); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_checks++;
        if (expired !== 1'b0) $display("FAIL reset_expired got=%b exp=0", expired); else n_pass++;
        n_checks++;
        if (state_dbg !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); else n_pass++;
    endtask

    task automatic test_basic(input int ld);
        logic [W-1:0] exp;
        logic         exp_busy, exp_done, exp_exp;
        exp_q.delete();
        for (int t = 0; t <= ld * P; t++) exp_q.push_back(model_count(ld, t));
        count_in = W'(ld); start = 1'b1;
        step();
        for (int t = 0; t <= ld * P; t++) begin
            exp      = exp_q.pop_front();
            exp_busy = (t < ld * P);
            exp_done = (t == ld * P);
            exp_exp  = (t == ld * P);
            n_checks++;
            if (count_now !== exp)
                $display("FAIL basic_count n=%0d t=%0d got=%0d exp=%0d", ld, t, count_now, exp);
            else n_pass++;
            n_checks++;
            if (busy !== exp_busy || done !== exp_done || expired !== exp_exp)
                $display("FAIL basic_flags n=%0d t=%0d got busy=%b done=%b expired=%b exp %b %b %b",
                         ld, t, busy, done, expired, exp_busy, exp_done, exp_exp);
            else n_pass++;
            count_in = W'($urandom);
            step();
        end
        n_checks++;
        if (done !== 1'b0 || expired !== 1'b1 || state_dbg !== IDLE)
            $display("FAIL basic_after n=%0d got done=%b expired=%b state=%0d exp 0 1 %0d",
                     ld, done, expired, state_dbg, IDLE);
        else n_pass++;
        start = 1'b0;
        step();
    endtask

    task automatic test_zero();
        count_in = '0; start = 1'b1;
        step();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || count_now !== '0 || expired !== 1'b1)
            $display("FAIL zero_load got done=%b busy=%b count=%0d expired=%b exp 1 0 0 1",
                     done, busy, count_now, expired);
        else n_pass++;
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || expired !== 1'b1)
            $display("FAIL zero_after got done=%b busy=%b expired=%b exp 0 0 1", done, busy, expired);
        else n_pass++;
        start = 1'b0;
        step();
    endtask

    task automatic test_abort(input int ld, input int at);
        logic [W-1:0] held;
        held = model_count(ld, at);
        count_in = W'(ld); start = 1'b1;
        step();
        for (int t = 0; t < at; t++) step();
        n_checks++;
        if (count_now !== held) $display("FAIL abort_pre n=%0d t=%0d got=%0d exp=%0d", ld, at, count_now, held);
        else n_pass++;
        abort = 1'b1;
        for (int t = 0; t < 2 * P; t++) begin
            step();
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || count_now !== held || expired !== 1'b0)
                $display("FAIL abort_hold n=%0d at=%0d got busy=%b done=%b count=%0d expired=%b exp 0 0 %0d 0",
                         ld, at, busy, done, count_now, expired, held);
            else n_pass++;
        end
        abort = 1'b0; start = 1'b0;
        step();
    endtask

    task automatic test_restart(input int ld, input int t_drop, input int ld2);
        logic [W-1:0] exp;
        count_in = W'(ld); start = 1'b1;
        step();
        for (int t = 0; t < t_drop; t++) step();
        start = 1'b0;
        step();
        exp = model_count(ld, t_drop + 1);
        n_checks++;
        if (count_now !== exp || busy !== 1'b1)
            $display("FAIL restart_pre got count=%0d busy=%b exp %0d 1", count_now, busy, exp);
        else n_pass++;
        count_in = W'(ld2); start = 1'b1;
        step();
        for (int t = 0; t <= P; t++) begin
            exp = model_count(ld2, t);
            n_checks++;
            if (count_now !== exp || busy !== 1'b1)
                $display("FAIL restart_run t=%0d got count=%0d busy=%b exp %0d 1", t, count_now, busy, exp);
            else n_pass++;
            count_in = W'($urandom);
            if (t < P) step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        step();
    endtask

    task automatic test_abort_rise(input int ld, input int at);
        logic [W-1:0] held;
        count_in = W'(ld); start = 1'b1;
        step();
        for (int t = 0; t < at; t++) step();
        start = 1'b0;
        step();
        held = model_count(ld, at + 1);
        abort = 1'b1; start = 1'b1; count_in = W'($urandom_range(1, 200));
        step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || count_now !== held)
            $display("FAIL abort_rise got busy=%b done=%b count=%0d exp 0 0 %0d", busy, done, count_now, held);
        else n_pass++;
        abort = 1'b0;
        step(); step();
        n_checks++;
        if (busy !== 1'b0 || count_now !== held)
            $display("FAIL abort_rise_after got busy=%b count=%0d exp 0 %0d", busy, count_now, held);
        else n_pass++;
        start = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        count_in = W'(5); start = 1'b1;
        step();
        for (int t = 0; t < P; t++) step();
        n_checks++;
        if (count_now !== W'(4)) $display("FAIL reset_mid_pre got=%0d exp=4", count_now); else n_pass++;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        n_checks++;
        if (count_now !== '0 || busy !== 1'b0 || done !== 1'b0 || expired !== 1'b0 || state_dbg !== IDLE)
            $display("FAIL reset_mid got count=%0d busy=%b done=%b expired=%b state=%0d exp all 0",
                     count_now, busy, done, expired, state_dbg);
        else n_pass++;
        for (int t = 0; t < 3; t++) begin
            step();
            n_checks++;
            if (busy !== 1'b0 || count_now !== '0)
                $display("FAIL reset_held_start t=%0d got busy=%b count=%0d exp 0 0", t, busy, count_now);
            else n_pass++;
        end
        start = 1'b0;
        step();
        count_in = W'(2); start = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b1 || count_now !== W'(2))
            $display("FAIL reset_reload got busy=%b count=%0d exp 1 2", busy, count_now);
        else n_pass++;
        abort = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        step();
    endtask

`ifdef PIO_COUNT_TIMER_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        logic exp_done;
        int   pulses;
        pulses = 0;
        count_in = W'(2); start = 1'b1;
        step();
        for (int t = 0; t <= 36; t++) begin
            exp_done = (t >= 2 * P) && ((t - 2 * P) % (2 * P + 1) == 0);
            if (done === 1'b1) pulses++;
            n_checks++;
            if (done !== exp_done || busy !== !exp_done)
                $display("FAIL auto_flags t=%0d got done=%b busy=%b exp %b %b", t, done, busy, exp_done, !exp_done);
            else n_pass++;
            if (t < 36) step();
        end
        n_checks++;
        if (pulses < 3) $display("FAIL auto_pulses got=%0d exp>=3", pulses); else n_pass++;
        abort = 1'b1;
        for (int t = 0; t < 20; t++) begin
            step();
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || count_now !== W'(2))
                $display("FAIL auto_abort t=%0d got busy=%b done=%b count=%0d exp 0 0 2", t, busy, done, count_now);
            else n_pass++;
        end
        abort = 1'b0; start = 1'b0;
        step();
    endtask
`else
    task automatic test_one_shot();
        count_in = W'(2); start = 1'b1;
        step();
        for (int t = 0; t < 2 * P; t++) step();
        n_checks++;
        if (done !== 1'b1) $display("FAIL one_shot_done got=%b exp=1", done); else n_pass++;
        for (int t = 0; t < 3 * (2 * P + 1); t++) begin
            step();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || count_now !== '0)
                $display("FAIL one_shot_idle t=%0d got done=%b busy=%b count=%0d exp 0 0 0", t, done, busy, count_now);
            else n_pass++;
        end
        start = 1'b0;
        step();
    endtask
`endif

    initial begin
        do_reset();
        test_reset();
        test_basic(3);
        repeat (4) begin
            n = $urandom_range(1, 6);
            test_basic(n);
        end
        test_zero();
        test_abort(5, 12);
        repeat (3) begin
            n = $urandom_range(2, 7);
            a = $urandom_range(0, n * P - 1);
            test_abort(n, a);
        end
        test_restart(5, 7, 9);
        repeat (2) begin
            n = $urandom_range(2, 7);
            a = $urandom_range(0, n * P - 2);
            m = $urandom_range(2, 12);
            test_restart(n, a, m);
        end
        test_abort_rise(5, 5);
        n = $urandom_range(2, 7);
        a = $urandom_range(0, n * P - 2);
        test_abort_rise(n, a);
        test_reset_mid();
`ifdef PIO_COUNT_TIMER_AUTO_RELOAD_EN
        test_auto_reload();
`else
        test_one_shot();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
